// File: rtl/seq_isqrt_if.sv
// seq_isqrt_if: operand/result handshake bundle for the sequential square-root unit.
interface seq_isqrt_if #(parameter int IN_WIDTH = 32);
  logic                  in_valid;
  logic                  in_ready;
  logic [IN_WIDTH-1:0]   in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [IN_WIDTH/2-1:0] out_root;
  logic [IN_WIDTH/2:0]   out_rem;
  logic                  busy;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_root, out_rem, busy);
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_root, out_rem, busy);
endinterface

// File: rtl/seq_isqrt.sv
// seq_isqrt: digit-by-digit unsigned integer square root, one root bit per clock.
module seq_isqrt #(parameter int IN_WIDTH = 32) (
  input logic        clk,
  input logic        rst_n,
  seq_isqrt_if.slave io
);
  localparam int ROOT_W = IN_WIDTH / 2;
  localparam int REM_W = ROOT_W + 1;
  localparam int CW = $clog2(ROOT_W);
  if (IN_WIDTH % 2 != 0 || IN_WIDTH < 4) begin : g_bad_width
    $error("seq_isqrt: IN_WIDTH must be even and at least 4");
  end
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [IN_WIDTH-1:0] sr, sr_nx, op, op_nx;
  logic [ROOT_W-1:0] root, root_nx;
  logic [REM_W-1:0] rem, rem_nx;
  logic [REM_W+1:0] rem_sh, trial, diff;
  logic ge;
  always_comb begin
    rem_sh = {rem, sr[IN_WIDTH-1 -: 2]};
    trial = (REM_W+2)'({root, 2'b01});
    diff = rem_sh - trial;
    ge = rem_sh >= trial;
    state_nx = state;
    cnt_nx = cnt;
    sr_nx = sr;
    op_nx = op;
    root_nx = root;
    rem_nx = rem;
    case (state)
      IDLE: if (io.in_valid) begin
        state_nx = CALC;
        sr_nx = io.in_data;
        op_nx = io.in_data;
        root_nx = '0;
        rem_nx = '0;
        cnt_nx = CW'(ROOT_W - 1);
      end
      CALC: begin
        sr_nx = sr << 2;
        root_nx = {root[ROOT_W-2:0], ge};
        rem_nx = REM_W'(ge ? diff : rem_sh);
        cnt_nx = cnt - CW'(1);
        state_nx = cnt == '0 ? DONE : CALC;
      end
      DONE: state_nx = io.out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
      op <= '0;
      root <= '0;
      rem <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      sr <= sr_nx;
      op <= op_nx;
      root <= root_nx;
      rem <= rem_nx;
    end
  assign io.in_ready = state == IDLE;
  assign io.out_valid = state == DONE;
  assign io.busy = state != IDLE;
  assign io.out_root = root;
  assign io.out_rem = rem;
  // op is kept only so the result can be cross-checked against the original radicand
  a_rem_bound: assert property (@(posedge clk) disable iff (!rst_n) io.out_valid |-> rem <= {root, 1'b0});
  a_exact: assert property (@(posedge clk) disable iff (!rst_n) io.out_valid |->
    (IN_WIDTH+1)'(root) * (IN_WIDTH+1)'(root) + (IN_WIDTH+1)'(rem) == (IN_WIDTH+1)'(op));
  a_hold: assert property (@(posedge clk) disable iff (!rst_n) io.out_valid && !io.out_ready |=>
    $stable(root) && $stable(rem));
endmodule

// File: tb/tb_seq_isqrt.sv
// tb_seq_isqrt: directed vectors on a 32-bit unit plus a shuffled full sweep of an 8-bit unit.
module tb_seq_isqrt;
  logic clk = 0;
  logic rst_n = 1;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  seq_isqrt_if #(.IN_WIDTH(32)) ia();
  seq_isqrt_if #(.IN_WIDTH(8)) ib();
  seq_isqrt #(.IN_WIDTH(32)) u_a (.clk(clk), .rst_n(rst_n), .io(ia));
  seq_isqrt #(.IN_WIDTH(8)) u_b (.clk(clk), .rst_n(rst_n), .io(ib));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic start32(input logic [31:0] d);
    check("ready_a", 64'(ia.in_ready), 64'd1);
    ia.in_valid = 1;
    ia.in_data = d;
    @(posedge clk);
    @(negedge clk);
    ia.in_valid = 0;
    ia.in_data = '0;
  endtask
  task automatic finish32(input string tag, input int lat0, input logic [15:0] er, input logic [16:0] em);
    int lat;
    lat = lat0;
    while (!ia.out_valid && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, "_lat"}, 64'(lat), 64'd16);
    check({tag, "_root"}, 64'(ia.out_root), 64'(er));
    check({tag, "_rem"}, 64'(ia.out_rem), 64'(em));
    if (ia.out_ready) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_idle"}, 64'({ia.in_ready, ia.out_valid}), 64'b10);
    end
  endtask
  initial begin
    int perm[256];
    int v, r, lat, n, j, t;
    logic ghost;
    ia.in_valid = 0; ia.in_data = '0; ia.out_ready = 1;
    ib.in_valid = 0; ib.in_data = '0; ib.out_ready = 1;
    #3 rst_n = 0;
    #1;
    check("rst_a", 64'({ia.in_ready, ia.out_valid, ia.busy, ia.out_root, ia.out_rem}), {28'd0, 3'b100, 33'd0});
    check("rst_b", 64'({ib.in_ready, ib.out_valid, ib.busy, ib.out_root, ib.out_rem}), {52'd0, 3'b100, 9'd0});
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    start32(0);          finish32("d0", 0, 16'd0, 17'd0);
    start32(16);         finish32("d16", 0, 16'd4, 17'd0);
    start32(17);         finish32("d17", 0, 16'd4, 17'd1);
    start32(99);         finish32("d99", 0, 16'd9, 17'd18);
    start32(1000000);    finish32("d1e6", 0, 16'd1000, 17'd0);
    start32(32'hFFFFFFFF); finish32("dfull", 0, 16'hFFFF, 17'h1FFFE);
    // backpressure: result held while out_ready is low, with a competing operand offered
    ia.out_ready = 0;
    start32(15);
    finish32("bp", 0, 16'd3, 17'd6);
    ia.in_valid = 1;
    ia.in_data = 99;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_hold", 64'({ia.out_valid, ia.in_ready, ia.out_root, ia.out_rem}), {29'd0, 2'b10, 16'd3, 17'd6});
    end
    ia.out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release", 64'({ia.in_ready, ia.out_valid, ia.busy}), 64'b100);
    ia.in_valid = 0;
    ia.in_data = '0;
    start32(36);
    repeat (3) begin
      ia.in_valid = 1;
      ia.in_data = 50;
      @(posedge clk);
      @(negedge clk);
    end
    ia.in_valid = 0;
    finish32("p36", 3, 16'd6, 17'd0);
    start32(50);         finish32("p50", 0, 16'd7, 17'd1);
    // asynchronous reset between edges during the fifth CALC step
    start32(1000);
    repeat (5) @(posedge clk);
    #2 rst_n = 0;
    #1 check("rst_mid", 64'({ia.busy, ia.out_valid, ia.in_ready, ia.out_root, ia.out_rem}), {28'd0, 3'b001, 33'd0});
    repeat (2) @(negedge clk);
    rst_n = 1;
    ghost = 0;
    repeat (20) begin
      @(negedge clk);
      ghost |= ia.out_valid;
    end
    check("no_ghost", 64'(ghost), 64'd0);
    start32(81);         finish32("r81", 0, 16'd9, 17'd0);
    for (int i = 0; i < 256; i++) perm[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int k = 0; k < 256; k++) begin
      v = perm[k];
      r = 0;
      while ((r + 1) * (r + 1) <= v) r++;
      check("sw_ready", 64'(ib.in_ready), 64'd1);
      ib.out_ready = 1'($urandom_range(0, 1));
      ib.in_valid = 1;
      ib.in_data = 8'(v);
      @(posedge clk);
      @(negedge clk);
      ib.in_valid = 0;
      lat = 0;
      while (!ib.out_valid && lat < 20) begin
        ib.out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
      check("sw_lat", 64'(lat), 64'd4);
      check("sw_root", 64'(ib.out_root), 64'(r));
      check("sw_rem", 64'(ib.out_rem), 64'(v - r * r));
      n = 0;
      while (ib.out_valid && n < 60) begin
        ib.out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        n++;
        @(negedge clk);
      end
      check("sw_drain", 64'(ib.out_valid), 64'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/seq_isqrt.md
Name: seq_isqrt

Overview:
- Multi-cycle unsigned integer square root unit. It is the inverse of the squaring/sum-of-squares path.
- It takes the accumulated sum-of-squares word (int-width) and returns the floor root plus the remainder.
- It produces one root bit per clock.
- It sits after the square-results adder in the distance datapath and replaces the combinational sqrt loop.
- Valid/ready handshakes on both sides let it be stalled by downstream logic.

Parameters:
- IN_WIDTH, 32: operand width in bits. Must be even and at least 4; elaboration-time error otherwise.
- ROOT_W (localparam), IN_WIDTH/2: root width.
- REM_W (localparam), IN_WIDTH/2+1: remainder width. The maximum remainder is 2*root.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: operand present.
- in_ready, output, 1: unit can accept an operand.
- in_data, input, IN_WIDTH: unsigned radicand.
- out_valid, output, 1: result present.
- out_ready, input, 1: downstream accepts the result.
- out_root, output, ROOT_W: floor(sqrt(in_data)).
- out_rem, output, REM_W: in_data - out_root^2.
- busy, output, 1: high in CALC or DONE.

Behaviour:
- Reset (rst_n low, asynchronous, effective immediately):
  - state = IDLE, iteration counter = 0.
  - Internal radicand, root and remainder registers = 0.
  - out_valid = 0, out_root = 0, out_rem = 0, busy = 0.
  - in_ready = 1 once in IDLE.
- Reset mid-operation: the computation is abandoned and no result is emitted. The first cycle after deassertion is IDLE.
- States:
  - IDLE: in_ready = 1. On in_valid & in_ready:
    - latch in_data into the shift register; clear root and remainder; set counter = ROOT_W-1;
    - go to CALC.
  - CALC: in_ready = 0. Each cycle executes one digit-by-digit step:
    - rem' = (rem << 2) | top two bits of the shift register; shift register <<= 2;
    - trial = (root << 2) | 1;
    - if rem' >= trial: rem = rem' - trial, root = (root << 1) | 1;
    - else: rem = rem', root = root << 1.
    - Counter decrements each step. On the step where counter == 0, go to DONE.
  - DONE: out_valid = 1; out_root and out_rem hold stable. On out_valid & out_ready, go to IDLE and clear out_valid.
- Arithmetic widths:
  - All arithmetic is unsigned.
  - The remainder datapath is REM_W+2 bits internally so the shift cannot overflow.
  - The trial compare is unsigned at the same width.
  - The final remainder always fits REM_W.
- Latency:
  - Operand accepted at clock edge k.
  - ROOT_W CALC steps execute on edges k+1 .. k+ROOT_W.
  - out_valid is high after edge k+ROOT_W: 16 cycles for IN_WIDTH=32.
- Throughput and handshake rules:
  - One operation in flight. in_ready stays low from acceptance until the cycle after the output handshake.
  - No input is accepted in the same cycle as the output handshake.
  - in_data is ignored whenever in_ready = 0.
  - in_valid may drop without an accept; nothing is latched.
- Backpressure: DONE is held indefinitely while out_ready = 0. Outputs stay stable; no spurious toggling.
- out_ready outside DONE is ignored.
- Boundary values:
  - in_data = 0 gives root 0, rem 0.
  - in_data = all-ones must not overflow the remainder.
  - Full-scale input still takes exactly ROOT_W cycles; there is no early termination.
- Assertions (simulation-only):
  - out_rem <= 2*out_root when out_valid.
  - out_root^2 + out_rem == latched operand.
  - out_root/out_rem stable while out_valid & !out_ready.

Test Plan:
- Directed values, IN_WIDTH=32, out_ready=1:
  - 0 -> root 0, rem 0.
  - 16 -> 4, 0.
  - 17 -> 4, 1.
  - 99 -> 9, 18.
  - 1000000 -> 1000, 0.
  - out_valid rises exactly 16 cycles after the accept edge.
- Full scale: 0xFFFFFFFF -> root 65535 (0xFFFF), rem 131070 (0x1FFFE). No overflow; both assertions hold.
- Backpressure:
  - Operand 15 with out_ready=0 for 10 cycles after DONE -> root 3, rem 6 held stable; in_ready stays 0.
  - Raising out_ready completes the handshake; in_ready = 1 the next cycle.
- Input protocol: pulse in_valid with 50 during CALC of a prior op (operand 36) -> 50 is ignored; result is 6, 0.
  - Then a back-to-back accept of 50 in IDLE -> 7, 1.
- Reset mid-op: assert rst_n=0 asynchronously (between edges) at CALC step 5 of operand 1000 -> outputs zero immediately.
  - No out_valid ever appears for that operand.
  - After release, operand 81 -> 9, 0.
- Parameter sweep: IN_WIDTH=8, all 256 inputs randomly ordered with random out_ready -> compare against a reference model. Example: 255 -> 15, 30. Latency is 4 cycles.
